// File: rtl/mio_bus_pkg.sv
// Shared types and constants for the MIO bus arbiter, the bus decoder and the benches.
// The MIO_ARB_LOCK_EN build option uses lock_w() to size the M1 lock-run counter.
package mio_bus_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } master_e;

  // Address region tags (addr[31:28]) used by the bus decoder.
  localparam logic [3:0] RAM   = 4'h0;
  localparam logic [3:0] GPIOE = 4'he;
  localparam logic [3:0] GPIOF = 4'hf;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mio_req_t;

  function automatic int unsigned lock_w(input int unsigned lock_max);
    return $clog2(lock_max + 1);
  endfunction

endpackage

// File: rtl/mio_bus_if.sv
// Two-master MIO bus bundle: master-side request/ack pairs plus the shared bus.
// m1_lock exists only when MIO_ARB_LOCK_EN is defined.
interface mio_bus_if import mio_bus_pkg::*; ();

  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic [DATA_W-1:0] m0_rdata;
  logic              m0_ack;

  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic [DATA_W-1:0] m1_rdata;
  logic              m1_ack;
`ifdef MIO_ARB_LOCK_EN
  logic              m1_lock;
`endif

  logic              mem_w;
  logic [ADDR_W-1:0] addr_bus;
  logic [DATA_W-1:0] Cpu_data2bus;
  logic [DATA_W-1:0] Cpu_data4bus;
  logic              busy;

  // Requesters and the bus responder.
  modport master (
`ifdef MIO_ARB_LOCK_EN
    output m1_lock,
`endif
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output Cpu_data4bus,
    input  m0_rdata, m0_ack, m1_rdata, m1_ack,
    input  mem_w, addr_bus, Cpu_data2bus, busy
  );

  // The arbiter.
  modport slave (
`ifdef MIO_ARB_LOCK_EN
    input  m1_lock,
`endif
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  Cpu_data4bus,
    output m0_rdata, m0_ack, m1_rdata, m1_ack,
    output mem_w, addr_bus, Cpu_data2bus, busy
  );

endinterface

// File: rtl/mio_rr_pick.sv
// Combinational winner select: single requester wins, ties alternate against last_grant,
// and an active M1 lock run (lock_cnt in 1..LOCK_MAX-1) keeps M1 on the bus.
module mio_rr_pick import mio_bus_pkg::*; #(
  parameter int unsigned LOCK_MAX = 4,
  parameter int unsigned LOCK_W   = 3
) (
  input  logic [1:0]        req,
  input  master_e           last_grant,
  input  logic [LOCK_W-1:0] lock_cnt,
  output logic              valid_c,
  output master_e           grant_c
);

  logic lock_hold;

  always_comb begin
    lock_hold = (last_grant == M1) && req[1] && (lock_cnt != '0) &&
                (lock_cnt < LOCK_W'(LOCK_MAX));
    valid_c   = |req;
    grant_c   = M0;
    if (lock_hold) begin
      grant_c = M1;
    end else if (req == 2'b11) begin
      grant_c = (last_grant == M0) ? M1 : M0;
    end else if (req[1]) begin
      grant_c = M1;
    end
  end

endmodule

// File: rtl/mio_bus_arbiter.sv
// Two-master MIO bus arbiter: one transaction at a time, one-cycle write strobe,
// fixed RD_LAT read wait, one-cycle ack. Define MIO_ARB_LOCK_EN for M1 lock runs.
module mio_bus_arbiter import mio_bus_pkg::*; #(
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned LOCK_MAX = 4
) (
  input logic      clk,
  input logic      rst,
  mio_bus_if.slave bus
);

  localparam int unsigned LOCK_W = lock_w(LOCK_MAX);

  state_e            state_q, state_d;
  master_e           grant_q, grant_d;
  master_e           last_q, last_d;
  logic              we_q, we_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              mem_w_q, mem_w_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic [DATA_W-1:0] rd0_q, rd0_d;
  logic [DATA_W-1:0] rd1_q, rd1_d;
  logic              busy_q, busy_d;
  logic [LOCK_W-1:0] lock_cnt;

  logic              valid_c;
  master_e           win_c;
  mio_req_t          sel_c;

`ifdef MIO_ARB_LOCK_EN
  logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
  assign lock_cnt = lock_cnt_q;
`else
  assign lock_cnt = '0;
`endif

  mio_rr_pick #(
    .LOCK_MAX (LOCK_MAX),
    .LOCK_W   (LOCK_W)
  ) u_pick (
    .req        ({bus.m1_req, bus.m0_req}),
    .last_grant (last_q),
    .lock_cnt   (lock_cnt),
    .valid_c    (valid_c),
    .grant_c    (win_c)
  );

  // Winner's request fields, latched on the IDLE->XFER edge.
  always_comb begin
    if (win_c == M1) begin
      sel_c.we    = bus.m1_we;
      sel_c.addr  = bus.m1_addr;
      sel_c.wdata = bus.m1_wdata;
    end else begin
      sel_c.we    = bus.m0_we;
      sel_c.addr  = bus.m0_addr;
      sel_c.wdata = bus.m0_wdata;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mem_w_d = 1'b0;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    rd0_d   = rd0_q;
    rd1_d   = rd1_q;
    busy_d  = busy_q;
`ifdef MIO_ARB_LOCK_EN
    lock_cnt_d = lock_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (valid_c) begin
          grant_d = win_c;
          we_d    = sel_c.we;
          addr_d  = sel_c.addr;
          wdata_d = sel_c.wdata;
          mem_w_d = sel_c.we;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = XFER;
`ifdef MIO_ARB_LOCK_EN
          if ((win_c == M1) && bus.m1_lock) begin
            lock_cnt_d = (lock_cnt_q == LOCK_W'(LOCK_MAX)) ? lock_cnt_q
                                                          : lock_cnt_q + LOCK_W'(1);
          end else begin
            lock_cnt_d = '0;
          end
`endif
        end
      end
      XFER: begin
        // Writes leave after the strobe cycle; reads sample on the last wait cycle.
        if (we_q || (cnt_q == CNT_W'(RD_LAT - 1))) begin
          state_d = DONE;
          if (grant_q == M1) begin
            ack1_d = 1'b1;
            if (!we_q) rd1_d = bus.Cpu_data4bus;
          end else begin
            ack0_d = 1'b1;
            if (!we_q) rd0_d = bus.Cpu_data4bus;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        last_d  = grant_q;
        addr_d  = '0;
        wdata_d = '0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        addr_d  = '0;
        wdata_d = '0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= M0;
      last_q  <= M1;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      mem_w_q <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      rd0_q   <= '0;
      rd1_q   <= '0;
      busy_q  <= 1'b0;
`ifdef MIO_ARB_LOCK_EN
      lock_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mem_w_q <= mem_w_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
      busy_q  <= busy_d;
`ifdef MIO_ARB_LOCK_EN
      lock_cnt_q <= lock_cnt_d;
`endif
    end
  end

  assign bus.mem_w        = mem_w_q;
  assign bus.addr_bus     = addr_q;
  assign bus.Cpu_data2bus = wdata_q;
  assign bus.busy         = busy_q;
  assign bus.m0_ack       = ack0_q;
  assign bus.m1_ack       = ack1_q;
  assign bus.m0_rdata     = rd0_q;
  assign bus.m1_rdata     = rd1_q;

endmodule

// File: tb/tb_mio_bus_arbiter.sv
// Bench for mio_bus_arbiter: transaction-level model checked every cycle, plus directed
// literal checks. Lock-run scenario is included when MIO_ARB_LOCK_EN is defined.
module tb_mio_bus_arbiter;

  localparam int unsigned RD_LAT   = 2;
  localparam int unsigned LOCK_MAX = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mio_bus_if bus ();

  mio_bus_arbiter #(
    .RD_LAT   (RD_LAT),
    .LOCK_MAX (LOCK_MAX)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model state: a granted transaction occupies the bus for m_left more cycles.
  int          m_left;
  bit          m_who, m_we, m_last;
  logic [31:0] m_addr, m_wdata;
  int          m_run;
  logic        e_mem_w, e_busy, e_ack0, e_ack1;
  logic [31:0] e_addr, e_wdata, e_rd0, e_rd1;

  int          n_ack0 = 0, n_ack1 = 0, n_memw = 0, cyc = 0;
  bit          order[$];
  logic [31:0] w_addr, w_data;
  int          age = 0;
  bit          p_busy = 1'b0;
  logic [31:0] p_addr = '0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return a ^ 32'hF000_12A5;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_left = 0; m_last = 1'b1; m_run = 0;
    e_mem_w = 1'b0; e_busy = 1'b0; e_ack0 = 1'b0; e_ack1 = 1'b0;
    e_addr = '0; e_wdata = '0; e_rd0 = '0; e_rd1 = '0;
  endtask

  task automatic model_step();
    bit r0, r1, lk, w;
    r0 = bus.m0_req; r1 = bus.m1_req; lk = 1'b0;
`ifdef MIO_ARB_LOCK_EN
    lk = bus.m1_lock;
`endif
    e_mem_w = 1'b0; e_ack0 = 1'b0; e_ack1 = 1'b0;
    if (m_left > 0) begin
      m_left--;
      if (m_left == 1) begin
        if (m_who) e_ack1 = 1'b1; else e_ack0 = 1'b1;
        if (!m_we) begin
          if (m_who) e_rd1 = mem_rd(m_addr); else e_rd0 = mem_rd(m_addr);
        end
      end
      if (m_left == 0) begin
        e_busy = 1'b0; e_addr = '0; e_wdata = '0; m_last = m_who;
      end
    end else if (r0 || r1) begin
      if (r0 && r1) begin
        w = !m_last;
`ifdef MIO_ARB_LOCK_EN
        if (m_last && m_run > 0 && m_run < int'(LOCK_MAX)) w = 1'b1;
`endif
      end else begin
        w = r1;
      end
      m_who   = w;
      m_we    = w ? bus.m1_we : bus.m0_we;
      m_addr  = w ? bus.m1_addr : bus.m0_addr;
      m_wdata = w ? bus.m1_wdata : bus.m0_wdata;
      m_left  = (m_we ? 1 : int'(RD_LAT)) + 1;
      m_run   = (w && lk) ? ((m_run < int'(LOCK_MAX)) ? m_run + 1 : m_run) : 0;
      e_busy = 1'b1; e_addr = m_addr; e_wdata = m_wdata; e_mem_w = m_we;
    end
  endtask

  // Model update, per-cycle compare, monitors and the read-latency bus responder.
  always @(posedge clk) begin
    if (rst) model_reset(); else model_step();
    #1;
    cyc++;
    check("mem_w", 32'(bus.mem_w), 32'(e_mem_w));
    check("busy", 32'(bus.busy), 32'(e_busy));
    check("addr_bus", bus.addr_bus, e_addr);
    check("Cpu_data2bus", bus.Cpu_data2bus, e_wdata);
    check("m0_ack", 32'(bus.m0_ack), 32'(e_ack0));
    check("m1_ack", 32'(bus.m1_ack), 32'(e_ack1));
    if (e_ack0) check("m0_rdata", bus.m0_rdata, e_rd0);
    if (e_ack1) check("m1_rdata", bus.m1_rdata, e_rd1);
    if (bus.m0_ack) begin n_ack0++; order.push_back(1'b0); end
    if (bus.m1_ack) begin n_ack1++; order.push_back(1'b1); end
    if (bus.mem_w) begin n_memw++; w_addr = bus.addr_bus; w_data = bus.Cpu_data2bus; end
    if (bus.busy && p_busy && bus.addr_bus == p_addr) age++;
    else age = bus.busy ? 1 : 0;
    p_busy = bus.busy;
    p_addr = bus.addr_bus;
    bus.Cpu_data4bus = (bus.busy && age >= int'(RD_LAT)) ? mem_rd(bus.addr_bus)
                                                         : (32'hBAD0_0000 ^ 32'(cyc));
  end

  task automatic drive(input bit who, input bit req, input bit we,
                       input logic [31:0] addr, input logic [31:0] wdata, input bit lock);
    if (who) begin
      bus.m1_req = req; bus.m1_we = we; bus.m1_addr = addr; bus.m1_wdata = wdata;
`ifdef MIO_ARB_LOCK_EN
      bus.m1_lock = lock;
`endif
    end else begin
      bus.m0_req = req; bus.m0_we = we; bus.m0_addr = addr; bus.m0_wdata = wdata;
    end
    if (lock && !who) $display("note: lock ignored for m0");
  endtask

  // Issue at a negedge, wait (bounded) for the ack; lat counts clock edges to ack.
  task automatic do_txn(input bit who, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit lock, output int lat);
    bit got;
    drive(who, 1'b1, we, addr, wdata, lock);
    lat = 0; got = 1'b0;
    while (!got && lat < 50) begin
      @(negedge clk);
      lat++;
      got = who ? bus.m1_ack : bus.m0_ack;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL ack_timeout m%0d: no ack within %0d cycles", who, lat);
    end
    if (who) bus.m1_req = 1'b0; else bus.m0_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, b0, o0;
    bit got;
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    bus.Cpu_data4bus = '0;
    repeat (3) @(negedge clk);
    check("rst busy", 32'(bus.busy), 32'h0);
    check("rst mem_w", 32'(bus.mem_w), 32'h0);
    check("rst addr_bus", bus.addr_bus, 32'h0);
    check("rst m0_ack", 32'(bus.m0_ack), 32'h0);
    check("rst m1_ack", 32'(bus.m1_ack), 32'h0);
    check("rst m1_rdata", bus.m1_rdata, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Single M0 write.
    b0 = n_memw;
    do_txn(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, lat);
    check("t1 ack latency", 32'(lat), 32'd2);
    check("t1 mem_w pulses", 32'(n_memw - b0), 32'd1);
    check("t1 strobe addr", w_addr, 32'h0000_0010);
    check("t1 strobe data", w_data, 32'hDEAD_BEEF);
    repeat (2) @(negedge clk);

    // Single M1 read, RD_LAT=2.
    b0 = n_memw;
    do_txn(1'b1, 1'b0, 32'hF000_0000, 32'h0, 1'b0, lat);
    check("t2 ack latency", 32'(lat), 32'd3);
    check("t2 m1_rdata", bus.m1_rdata, 32'h0000_12A5);
    check("t2 mem_w pulses", 32'(n_memw - b0), 32'd0);
    check("t2 m0_rdata held", bus.m0_rdata, 32'h0);
    repeat (2) @(negedge clk);

    // Both masters, four writes each, back to back.
    b0 = n_memw; o0 = order.size();
    fork
      begin
        int l;
        for (int i = 0; i < 4; i++) do_txn(1'b0, 1'b1, 32'h100 + 32'(i * 4), 32'hA0 + 32'(i), 1'b0, l);
      end
      begin
        int l;
        for (int i = 0; i < 4; i++) do_txn(1'b1, 1'b1, 32'h200 + 32'(i * 4), 32'hB0 + 32'(i), 1'b0, l);
      end
    join
    @(negedge clk);
    check("t3 mem_w pulses", 32'(n_memw - b0), 32'd8);
    check("t3 ack count", 32'(order.size() - o0), 32'd8);
    for (int i = 0; i < 8 && o0 + i < order.size(); i++)
      check($sformatf("t3 grant %0d", i), 32'(order[o0 + i]), 32'(i % 2));
    repeat (2) @(negedge clk);

    // M0 read; address changes and req drops one cycle after grant.
    b0 = n_ack0;
    drive(1'b0, 1'b1, 1'b0, 32'h0000_0020, 32'h0, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'h0000_3000, 32'h0, 1'b0);
    lat = 1; got = bus.m0_ack;
    while (!got && lat < 50) begin
      @(negedge clk);
      lat++;
      got = bus.m0_ack;
    end
    check("t4 ack latency", 32'(lat), 32'd3);
    check("t4 m0_rdata", bus.m0_rdata, 32'hF000_1285);
    repeat (3) @(negedge clk);
    check("t4 m0 ack pulses", 32'(n_ack0 - b0), 32'd1);
    do_txn(1'b1, 1'b1, 32'h0000_0044, 32'h5555_AAAA, 1'b0, lat);
    check("t4 m1 ack latency", 32'(lat), 32'd2);
    repeat (2) @(negedge clk);

    // Reset while a read is in XFER.
    drive(1'b0, 1'b1, 1'b0, 32'h0000_0040, 32'h0, 1'b0);
    @(posedge clk);
    #2;
    check("t5 busy before rst", 32'(bus.busy), 32'h1);
    #1 rst = 1'b1;
    #1;
    check("t5 rst busy", 32'(bus.busy), 32'h0);
    check("t5 rst addr_bus", bus.addr_bus, 32'h0);
    check("t5 rst data2bus", bus.Cpu_data2bus, 32'h0);
    check("t5 rst m0_ack", 32'(bus.m0_ack), 32'h0);
    check("t5 rst m1_rdata", bus.m1_rdata, 32'h0);
    bus.m0_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    b0 = n_ack0;
    repeat (4) @(negedge clk);
    check("t5 no ack after rst", 32'(n_ack0 - b0), 32'd0);
    do_txn(1'b0, 1'b0, 32'h0000_0040, 32'h0, 1'b0, lat);
    check("t5 fresh read latency", 32'(lat), 32'd3);
    check("t5 fresh m0_rdata", bus.m0_rdata, 32'hF000_12E5);
    repeat (2) @(negedge clk);

`ifdef MIO_ARB_LOCK_EN
    // Locked M1 run: M1 alone first, then both request.
    o0 = order.size();
    do_txn(1'b1, 1'b1, 32'h0000_0300, 32'hC0, 1'b1, lat);
    fork
      begin
        int l;
        for (int i = 1; i < 5; i++) do_txn(1'b1, 1'b1, 32'h300 + 32'(i * 4), 32'hC0 + 32'(i), 1'b1, l);
      end
      begin
        int l;
        do_txn(1'b0, 1'b1, 32'h0000_0400, 32'hD0, 1'b0, l);
      end
    join
    @(negedge clk);
    begin
      bit exp_ord[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      check("lock ack count", 32'(order.size() - o0), 32'd6);
      for (int i = 0; i < 6 && o0 + i < order.size(); i++)
        check($sformatf("lock grant %0d", i), 32'(order[o0 + i]), 32'(exp_ord[i]));
    end
    repeat (2) @(negedge clk);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
